// File: rtl/pipo_load_arbiter_if.sv
// Bus bundle for the shared PIPO load arbiter.
// Requesters drive req/req_data; the arbiter drives the rest.
interface pipo_load_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      parallel_out;
  logic                  out_valid;
  logic [IDW-1:0]        owner;
  logic                  busy;

  modport master (
    output req, req_data,
    input  gnt, parallel_out, out_valid, owner, busy
  );

  modport slave (
    input  req, req_data,
    output gnt, parallel_out, out_valid, owner, busy
  );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter owning one shared PIPO register.
// A load is followed by a HOLD window that freezes the word.
module pipo_load_arbiter #(
  parameter int WIDTH    = 4,
  parameter int NREQ     = 2,
  parameter int HOLD_CYC = 2
) (
  input logic               clk,
  input logic               rst,
  pipo_load_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   owner_q;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  gnt_q;
  logic [WIDTH-1:0] data_q;
  logic             out_valid_q;
  logic             found;
  logic             load;
  int               idx;

  // Pick the first eligible requester at or after the pointer.
  always_comb begin
    elig  = bus.req & ~gnt_q;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Next state: load from IDLE, count down the hold window.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          load = 1'b1;
          if (HOLD_CYC > 0) begin
            state_n = HOLD;
            cnt_n   = CNT_INIT;
          end
        end
      end
      HOLD: begin
        if (cnt == '0) state_n = IDLE;
        else cnt_n = cnt - 1'b1;
      end
    endcase
  end

  // State, shared register, grant pulse and pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      owner_q     <= '0;
      data_q      <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      gnt_q       <= '0;
      out_valid_q <= load;
      if (load) begin
        gnt_q[win] <= 1'b1;
        data_q     <= bus.req_data[win*WIDTH +: WIDTH];
        owner_q    <= win;
        ptr        <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.parallel_out = data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.owner        = owner_q;
  assign bus.busy         = (state == HOLD);
endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench for pipo_load_arbiter.
// Instance a: HOLD_CYC=2, instance z: HOLD_CYC=0.
module tb_pipo_load_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipo_load_arbiter_if #(.WIDTH(4), .NREQ(2)) a ();
  pipo_load_arbiter_if #(.WIDTH(4), .NREQ(2)) z ();

  pipo_load_arbiter #(.WIDTH(4), .NREQ(2), .HOLD_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave)
  );

  pipo_load_arbiter #(.WIDTH(4), .NREQ(2), .HOLD_CYC(0)) dut_z (
    .clk(clk), .rst(rst), .bus(z.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a.req = 2'b00; a.req_data = '0;
    z.req = 2'b00; z.req_data = '0;
    #1 rst = 1'b0;
    #1;
    checks++; if (a.parallel_out !== 4'b0000) begin errors++; $display("FAIL rst_async_po got %b want 0000", a.parallel_out); end
    checks++; if (a.gnt !== 2'b00) begin errors++; $display("FAIL rst_async_gnt got %b want 00", a.gnt); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b want 0", a.busy); end
    checks++; if (a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_ov got %b want 0", a.out_valid); end
    checks++; if (a.owner !== 1'b0) begin errors++; $display("FAIL rst_async_owner got %b want 0", a.owner); end
    a.req = 2'b11; a.req_data = {4'b1011, 4'b1111};
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if (a.parallel_out !== 4'b0000) begin errors++; $display("FAIL rst_hold_po[%0d] got %b want 0000", n, a.parallel_out); end
      checks++; if (a.gnt !== 2'b00) begin errors++; $display("FAIL rst_hold_gnt[%0d] got %b want 00", n, a.gnt); end
      checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy[%0d] got %b want 0", n, a.busy); end
    end
    a.req = 2'b00;
    rst = 1'b1;
    step();
    checks++; if (a.gnt !== 2'b00) begin errors++; $display("FAIL rst_noreq_gnt got %b want 00", a.gnt); end
  endtask

  task automatic test_single();
    a.req = 2'b01; a.req_data = {4'b0000, 4'b1111};
    step();
    a.req = 2'b00;
    checks++; if (a.parallel_out !== 4'b1111) begin errors++; $display("FAIL single_po got %b want 1111", a.parallel_out); end
    checks++; if (a.gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got %b want 01", a.gnt); end
    checks++; if (a.out_valid !== 1'b1) begin errors++; $display("FAIL single_ov got %b want 1", a.out_valid); end
    checks++; if (a.owner !== 1'b0) begin errors++; $display("FAIL single_owner got %b want 0", a.owner); end
    checks++; if (a.busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b want 1", a.busy); end
    step();
    checks++; if (a.busy !== 1'b1) begin errors++; $display("FAIL single_busy2 got %b want 1", a.busy); end
    checks++; if (a.gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_drop got %b want 00", a.gnt); end
    checks++; if (a.out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_drop got %b want 0", a.out_valid); end
    checks++; if (a.parallel_out !== 4'b1111) begin errors++; $display("FAIL single_po_hold got %b want 1111", a.parallel_out); end
    step();
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", a.busy); end
  endtask

  task automatic test_drop();
    do_reset();
    a.req = 2'b11; a.req_data = {4'b1100, 4'b1011};
    step();
    checks++; if (a.gnt !== 2'b01) begin errors++; $display("FAIL drop_gnt0 got %b want 01", a.gnt); end
    checks++; if (a.parallel_out !== 4'b1011) begin errors++; $display("FAIL drop_po0 got %b want 1011", a.parallel_out); end
    a.req = 2'b10;
    step();
    checks++; if (a.gnt !== 2'b00) begin errors++; $display("FAIL drop_gap1 got %b want 00", a.gnt); end
    step();
    checks++; if (a.gnt !== 2'b00) begin errors++; $display("FAIL drop_gap2 got %b want 00", a.gnt); end
    step();
    checks++; if (a.gnt !== 2'b10) begin errors++; $display("FAIL drop_gnt1 got %b want 10", a.gnt); end
    checks++; if (a.parallel_out !== 4'b1100) begin errors++; $display("FAIL drop_po1 got %b want 1100", a.parallel_out); end
    checks++; if (a.owner !== 1'b1) begin errors++; $display("FAIL drop_owner1 got %b want 1", a.owner); end
    a.req = 2'b00;
    step();
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] eg;
    logic [3:0] ep;
    do_reset();
    a.req = 2'b11; a.req_data = {4'b0101, 4'b0011};
    for (int n = 0; n < 4; n++) begin
      eg = (n % 2 == 0) ? 2'b01 : 2'b10;
      ep = (n % 2 == 0) ? 4'b0011 : 4'b0101;
      step();
      checks++; if (a.gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", n, a.gnt, eg); end
      checks++; if (a.owner !== eg[1]) begin errors++; $display("FAIL rr_owner[%0d] got %b want %b", n, a.owner, eg[1]); end
      checks++; if (a.parallel_out !== ep) begin errors++; $display("FAIL rr_po[%0d] got %b want %b", n, a.parallel_out, ep); end
      step();
      checks++; if (a.gnt !== 2'b00) begin errors++; $display("FAIL rr_hold_gnt[%0d] got %b want 00", n, a.gnt); end
      step();
    end
    a.req = 2'b00;
  endtask

  task automatic test_busy_req();
    do_reset();
    a.req = 2'b01; a.req_data = {4'b0110, 4'b1010};
    step();
    checks++; if (a.gnt !== 2'b01) begin errors++; $display("FAIL busy_gnt0 got %b want 01", a.gnt); end
    a.req = 2'b10;
    checks++; if (a.busy !== 1'b1) begin errors++; $display("FAIL busy_flag got %b want 1", a.busy); end
    step();
    checks++; if (a.gnt !== 2'b00) begin errors++; $display("FAIL busy_gnt_h1 got %b want 00", a.gnt); end
    checks++; if (a.parallel_out !== 4'b1010) begin errors++; $display("FAIL busy_po_h1 got %b want 1010", a.parallel_out); end
    step();
    checks++; if (a.gnt !== 2'b00) begin errors++; $display("FAIL busy_gnt_h2 got %b want 00", a.gnt); end
    checks++; if (a.parallel_out !== 4'b1010) begin errors++; $display("FAIL busy_po_h2 got %b want 1010", a.parallel_out); end
    step();
    checks++; if (a.gnt !== 2'b10) begin errors++; $display("FAIL busy_gnt1 got %b want 10", a.gnt); end
    checks++; if (a.parallel_out !== 4'b0110) begin errors++; $display("FAIL busy_po1 got %b want 0110", a.parallel_out); end
    a.req = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [1:0] eg;
    logic [3:0] ep;
    do_reset();
    z.req = 2'b11; z.req_data = {4'b0010, 4'b0001};
    for (int n = 0; n < 5; n++) begin
      eg = (n % 2 == 0) ? 2'b01 : 2'b10;
      ep = (n % 2 == 0) ? 4'b0001 : 4'b0010;
      step();
      checks++; if (z.gnt !== eg) begin errors++; $display("FAIL b2b_gnt[%0d] got %b want %b", n, z.gnt, eg); end
      checks++; if (z.parallel_out !== ep) begin errors++; $display("FAIL b2b_po[%0d] got %b want %b", n, z.parallel_out, ep); end
      checks++; if (z.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_ov[%0d] got %b want 1", n, z.out_valid); end
      checks++; if (z.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy[%0d] got %b want 0", n, z.busy); end
    end
    #1 rst = 1'b0;
    #1;
    checks++; if (z.parallel_out !== 4'b0000) begin errors++; $display("FAIL b2b_rst_po got %b want 0000", z.parallel_out); end
    checks++; if (z.gnt !== 2'b00) begin errors++; $display("FAIL b2b_rst_gnt got %b want 00", z.gnt); end
    checks++; if (z.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_rst_ov got %b want 0", z.out_valid); end
    #1 rst = 1'b1;
    step();
    checks++; if (z.gnt !== 2'b01) begin errors++; $display("FAIL b2b_restart_gnt got %b want 01", z.gnt); end
    checks++; if (z.parallel_out !== 4'b0001) begin errors++; $display("FAIL b2b_restart_po got %b want 0001", z.parallel_out); end
    z.req = 2'b00;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_drop();
    test_round_robin();
    test_busy_req();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
